// File: rtl/squarewave_phase_decoder.sv
// Square-wave sample decoder: recovers the phase top bit with hysteresis and
// measures period and first-half length in sample ticks.
module squarewave_phase_decoder #(
    parameter int USE_UNSIGNED_TABLES = 0,
    parameter int HYST                = 256,
    parameter int CNT_WIDTH           = 16,
    parameter int MIN_PERIOD          = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sampleValid,
    input  logic [11:0]          sample,
    output logic                 phaseTopBit,
    output logic [CNT_WIDTH-1:0] period,
    output logic [CNT_WIDTH-1:0] firstHalf,
    output logic                 periodValid,
    output logic                 locked,
    output logic                 timeout
);

    typedef enum logic [1:0] {
        ST_UNKNOWN = 2'd0,
        ST_SEEK    = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] MIN_P   = CNT_WIDTH'(MIN_PERIOD);
    localparam logic signed [12:0]   HYST_S  = 13'(HYST);
    localparam logic [12:0]          HI_U    = 13'(2048 + HYST);
    localparam logic [12:0]          LO_U    = 13'(2047 - HYST);

    state_t                 state_q, state_d;
    logic                   phase_q, phase_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]   hcnt_q, hcnt_d;
    logic [CNT_WIDTH-1:0]   period_q, period_d;
    logic [CNT_WIDTH-1:0]   first_half_q, first_half_d;
    logic                   period_valid_q, period_valid_d;
    logic                   locked_q, locked_d;
    logic                   timeout_q, timeout_d;

    logic                   cls_known_s;
    logic                   cls_bit_s;
    logic                   level_s;
    logic                   wrap_s;
    logic signed [12:0]     sample_sx_s;
    logic [12:0]            sample_ux_s;
    logic [CNT_WIDTH-1:0]   cnt_inc_s;
    logic [CNT_WIDTH-1:0]   hcnt_inc_s;

    assign sample_sx_s = {sample[11], sample};
    assign sample_ux_s = {1'b0, sample};

    // Classify the incoming sample into 0, 1 or in-band
    always_comb begin
        cls_known_s = 1'b0;
        cls_bit_s   = 1'b0;
        if (USE_UNSIGNED_TABLES != 0) begin
            if (sample_ux_s >= HI_U) begin
                cls_known_s = 1'b1;
                cls_bit_s   = 1'b0;
            end else if (sample_ux_s <= LO_U) begin
                cls_known_s = 1'b1;
                cls_bit_s   = 1'b1;
            end else begin
                cls_known_s = 1'b0;
                cls_bit_s   = 1'b0;
            end
        end else begin
            if (sample_sx_s >= HYST_S) begin
                cls_known_s = 1'b1;
                cls_bit_s   = 1'b1;
            end else if (sample_sx_s <= -HYST_S) begin
                cls_known_s = 1'b1;
                cls_bit_s   = 1'b0;
            end else begin
                cls_known_s = 1'b0;
                cls_bit_s   = 1'b0;
            end
        end
    end

    assign level_s    = cls_known_s ? cls_bit_s : phase_q;
    assign wrap_s     = sampleValid & cls_known_s & ~cls_bit_s & phase_q
                        & (state_q != ST_UNKNOWN);
    assign cnt_inc_s  = cnt_q + CNT_ONE;
    assign hcnt_inc_s = level_s ? hcnt_q : (hcnt_q + CNT_ONE);

    // Next-state and measurement update; only valid samples advance anything
    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        cnt_d          = cnt_q;
        hcnt_d         = hcnt_q;
        period_d       = period_q;
        first_half_d   = first_half_q;
        period_valid_d = 1'b0;
        locked_d       = locked_q;
        timeout_d      = timeout_q;
        if (sampleValid) begin
            case (state_q)
                ST_UNKNOWN: begin
                    if (cls_known_s) begin
                        phase_d = cls_bit_s;
                        state_d = ST_SEEK;
                    end else begin
                        state_d = ST_UNKNOWN;
                    end
                end
                ST_SEEK: begin
                    phase_d = level_s;
                    if (wrap_s) begin
                        cnt_d   = CNT_ONE;
                        hcnt_d  = CNT_ONE;
                        state_d = ST_MEASURE;
                    end else begin
                        state_d = ST_SEEK;
                    end
                end
                ST_MEASURE: begin
                    phase_d = level_s;
                    if (wrap_s) begin
                        cnt_d  = CNT_ONE;
                        hcnt_d = CNT_ONE;
                        // Periods shorter than MIN_PERIOD are glitches and are dropped
                        if (cnt_q >= MIN_P) begin
                            period_d       = cnt_q;
                            first_half_d   = hcnt_q;
                            period_valid_d = 1'b1;
                            locked_d       = 1'b1;
                            timeout_d      = 1'b0;
                        end else begin
                            period_valid_d = 1'b0;
                        end
                    end else if (cnt_inc_s == CNT_MAX) begin
                        cnt_d     = CNT_MAX;
                        hcnt_d    = hcnt_inc_s;
                        timeout_d = 1'b1;
                        locked_d  = 1'b0;
                        state_d   = ST_SEEK;
                    end else begin
                        cnt_d  = cnt_inc_s;
                        hcnt_d = hcnt_inc_s;
                    end
                end
                default: begin
                    state_d = ST_UNKNOWN;
                end
            endcase
        end else begin
            period_valid_d = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_UNKNOWN;
            phase_q        <= 1'b0;
            cnt_q          <= '0;
            hcnt_q         <= '0;
            period_q       <= '0;
            first_half_q   <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            cnt_q          <= cnt_d;
            hcnt_q         <= hcnt_d;
            period_q       <= period_d;
            first_half_q   <= first_half_d;
            period_valid_q <= period_valid_d;
            locked_q       <= locked_d;
            timeout_q      <= timeout_d;
        end
    end

    assign phaseTopBit = phase_q;
    assign period      = period_q;
    assign firstHalf   = first_half_q;
    assign periodValid = period_valid_q;
    assign locked      = locked_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_squarewave_phase_decoder.sv
// Bench for squarewave_phase_decoder: three configurations share one stimulus
// stream and are each checked against a wrap-index based reference model.
module tb_squarewave_phase_decoder;

    localparam int HYST = 256;
    localparam int MINP = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sampleValid = 1'b0;
    logic [11:0] sample = 12'h000;

    logic        pb [3];
    logic        pv [3];
    logic        lk [3];
    logic        to [3];
    logic [15:0] per_a, fh_a, per_b, fh_b;
    logic [3:0]  per_c, fh_c;

    squarewave_phase_decoder #(.USE_UNSIGNED_TABLES(0), .HYST(HYST), .CNT_WIDTH(16), .MIN_PERIOD(MINP)) u_s16 (
        .clk(clk), .rst_n(rst_n), .sampleValid(sampleValid), .sample(sample),
        .phaseTopBit(pb[0]), .period(per_a), .firstHalf(fh_a),
        .periodValid(pv[0]), .locked(lk[0]), .timeout(to[0]));

    squarewave_phase_decoder #(.USE_UNSIGNED_TABLES(1), .HYST(HYST), .CNT_WIDTH(16), .MIN_PERIOD(MINP)) u_u16 (
        .clk(clk), .rst_n(rst_n), .sampleValid(sampleValid), .sample(sample),
        .phaseTopBit(pb[1]), .period(per_b), .firstHalf(fh_b),
        .periodValid(pv[1]), .locked(lk[1]), .timeout(to[1]));

    squarewave_phase_decoder #(.USE_UNSIGNED_TABLES(0), .HYST(HYST), .CNT_WIDTH(4), .MIN_PERIOD(MINP)) u_s4 (
        .clk(clk), .rst_n(rst_n), .sampleValid(sampleValid), .sample(sample),
        .phaseTopBit(pb[2]), .period(per_c), .firstHalf(fh_c),
        .periodValid(pv[2]), .locked(lk[2]), .timeout(to[2]));

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;
    int cyc = 0;
    int pcnt [3];
    int last_pulse0, gap0;

    // Reference model: state 0 unknown, 1 seeking, 2 measuring
    int m_state [3], m_phase [3], m_per [3], m_fh [3], m_pv [3], m_lk [3], m_to [3];
    int m_idx [3], m_z [3], m_wi [3], m_zw [3];

    function automatic int umode(int i);
        return (i == 1) ? 1 : 0;
    endfunction

    function automatic int maxc(int i);
        return (i == 2) ? 15 : 65535;
    endfunction

    function automatic int dut_per(int i);
        return (i == 0) ? int'(per_a) : (i == 1) ? int'(per_b) : int'(per_c);
    endfunction

    function automatic int dut_fh(int i);
        return (i == 0) ? int'(fh_a) : (i == 1) ? int'(fh_b) : int'(fh_c);
    endfunction

    task automatic chk(input string name, input int inst, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s[%0d] at cycle %0d: got %0d, expected %0d", name, inst, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_state[i] = 0; m_phase[i] = 0; m_per[i] = 0; m_fh[i] = 0;
            m_pv[i] = 0; m_lk[i] = 0; m_to[i] = 0;
            m_idx[i] = 0; m_z[i] = 0; m_wi[i] = 0; m_zw[i] = 0;
        end
    endtask

    // Period is the index distance between wraps; firstHalf the zero-level count between them
    task automatic model_step(input bit v, input logic [11:0] s);
        for (int i = 0; i < 3; i++) begin
            int c, lvl, x, len;
            m_pv[i] = 0;
            if (v) begin
                if (umode(i) != 0) begin
                    x = int'(s);
                    c = (x >= 2048 + HYST) ? 0 : (x <= 2047 - HYST) ? 1 : -1;
                end else begin
                    x = int'($signed(s));
                    c = (x >= HYST) ? 1 : (x <= -HYST) ? 0 : -1;
                end
                lvl = (c < 0) ? m_phase[i] : c;
                if (m_state[i] == 0) begin
                    if (c >= 0) begin
                        m_phase[i] = c;
                        m_state[i] = 1;
                    end
                end else begin
                    len = m_idx[i] - m_wi[i];
                    if (c == 0 && m_phase[i] == 1) begin
                        if (m_state[i] == 2 && len >= MINP) begin
                            m_per[i] = len;
                            m_fh[i]  = m_z[i] - m_zw[i];
                            m_pv[i]  = 1;
                            m_lk[i]  = 1;
                            m_to[i]  = 0;
                        end
                        m_state[i] = 2;
                        m_wi[i] = m_idx[i];
                        m_zw[i] = m_z[i];
                    end else if (m_state[i] == 2 && len + 1 == maxc(i)) begin
                        m_to[i] = 1;
                        m_lk[i] = 0;
                        m_state[i] = 1;
                    end
                    m_phase[i] = lvl;
                end
                if (lvl == 0) m_z[i]++;
                m_idx[i]++;
            end
        end
    endtask

    // Every-cycle comparison of all three DUTs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk("phaseTopBit", i, int'(pb[i]), m_phase[i]);
                chk("period",      i, dut_per(i),  m_per[i]);
                chk("firstHalf",   i, dut_fh(i),   m_fh[i]);
                chk("periodValid", i, int'(pv[i]), m_pv[i]);
                chk("locked",      i, int'(lk[i]), m_lk[i]);
                chk("timeout",     i, int'(to[i]), m_to[i]);
            end
        end
    end

    task automatic tick(input bit v, input logic [11:0] s);
        sampleValid = v;
        sample      = s;
        @(posedge clk);
        model_step(v, s);
        cyc++;
        #2;
        for (int i = 0; i < 3; i++) if (pv[i]) pcnt[i]++;
        if (pv[0]) begin
            gap0 = cyc - last_pulse0;
            last_pulse0 = cyc;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_phase",  0, int'(pb[0]), 0);
        chk("rst_period", 0, int'(per_a), 0);
        chk("rst_locked", 0, int'(lk[0]), 0);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) pcnt[i] = 0;
    endtask

    task automatic sq_cycle(input int n_hi, input int n_lo, input bit gap);
        for (int k = 0; k < n_hi; k++) begin
            tick(1'b1, 12'h7FF);
            if (gap) tick(1'b0, 12'h801);
        end
        for (int k = 0; k < n_lo; k++) begin
            tick(1'b1, 12'h801);
            if (gap) tick(1'b0, 12'h7FF);
        end
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < 3; i++) pcnt[i] = 0;
        repeat (2) @(posedge clk);
        #2;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Signed 4/4 square wave
        tick(1'b1, 12'h7FF);
        chk("lat_phase", 0, int'(pb[0]), 1);
        tick(1'b1, 12'h7FF); tick(1'b1, 12'h7FF); tick(1'b1, 12'h7FF);
        sq_cycle(0, 4, 1'b0);
        for (int r = 0; r < 4; r++) sq_cycle(4, 4, 1'b0);
        chk("t1_period", 0, int'(per_a), 8);
        chk("t1_half",   0, int'(fh_a), 4);
        chk("t1_locked", 0, int'(lk[0]), 1);
        chk("t1_pulses", 0, pcnt[0], 4);
        chk("t1_period", 2, int'(per_c), 8);
        chk("t1_locked", 1, int'(lk[1]), 0);

        // Unsigned 6 x 0x000 / 10 x 0xFFF
        do_reset();
        for (int r = 0; r < 4; r++) begin
            repeat (6) tick(1'b1, 12'h000);
            chk("t2_phase_hi", 1, int'(pb[1]), 1);
            repeat (10) tick(1'b1, 12'hFFF);
            chk("t2_phase_lo", 1, int'(pb[1]), 0);
        end
        chk("t2_period", 1, int'(per_b), 16);
        chk("t2_half",   1, int'(fh_b), 10);
        chk("t2_pulses", 1, pcnt[1], 3);
        chk("t2_locked", 0, int'(lk[0]), 0);

        // Hysteresis band
        do_reset();
        tick(1'b1, 12'h7FF); chk("t3_p0", 0, int'(pb[0]), 1);
        tick(1'b1, 12'h0F0); chk("t3_p1", 0, int'(pb[0]), 1);
        tick(1'b1, 12'h801); chk("t3_p2", 0, int'(pb[0]), 0);
        tick(1'b1, 12'hF10); chk("t3_p3", 0, int'(pb[0]), 0);
        tick(1'b1, 12'h7FF); chk("t3_p4", 0, int'(pb[0]), 1);
        chk("t3_nopulse", 0, pcnt[0], 0);
        tick(1'b1, 12'h801);
        chk("t3_period", 0, int'(per_a), 3);
        chk("t3_half",   0, int'(fh_a), 2);

        // Gapped sampleValid
        do_reset();
        sq_cycle(4, 4, 1'b1);
        for (int r = 0; r < 4; r++) sq_cycle(4, 4, 1'b1);
        chk("t4_period", 0, int'(per_a), 8);
        chk("t4_half",   0, int'(fh_a), 4);
        chk("t4_pulses", 0, pcnt[0], 4);
        chk("t4_spacing", 0, gap0, 16);

        // Saturation on the 4-bit counter instance
        do_reset();
        sq_cycle(4, 4, 1'b0);
        tick(1'b1, 12'h7FF); tick(1'b1, 12'h7FF); tick(1'b1, 12'h7FF); tick(1'b1, 12'h7FF);
        repeat (14) tick(1'b1, 12'h801);
        chk("t5_pre_timeout", 2, int'(to[2]), 0);
        chk("t5_pre_locked",  2, int'(lk[2]), 1);
        tick(1'b1, 12'h801);
        chk("t5_timeout", 2, int'(to[2]), 1);
        chk("t5_locked",  2, int'(lk[2]), 0);
        chk("t5_period",  2, int'(per_c), 8);
        sq_cycle(4, 4, 1'b0);
        sq_cycle(4, 0, 1'b0);
        tick(1'b1, 12'h801);
        chk("t5_relock",   2, int'(lk[2]), 1);
        chk("t5_untimeout", 2, int'(to[2]), 0);
        chk("t5_period2",  2, int'(per_c), 8);

        // Reset in the middle of a measurement
        sq_cycle(4, 4, 1'b0);
        sq_cycle(3, 0, 1'b0);
        do_reset();
        sq_cycle(0, 4, 1'b0);
        sq_cycle(4, 4, 1'b0);
        sq_cycle(4, 0, 1'b0);
        chk("t6_nopulse", 0, pcnt[0], 0);
        tick(1'b1, 12'h801);
        chk("t6_pulses", 0, pcnt[0], 1);
        chk("t6_period", 0, int'(per_a), 8);

        tick(1'b0, 12'h000);
        tick(1'b0, 12'h000);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/squarewave_phase_decoder.md
Name: squarewave_phase_decoder

Overview:
- Receive-side counterpart of the square-wave lookup table.
- Takes the 12-bit square-wave sample stream that the table produces and recovers the phase top bit, using hysteresis.
- Measures the waveform period and the first-half length, in sample ticks.
- Sits after the oscillator/mixer output. Used for self-test and for tuning loops that check the synthesized frequency.

Parameters:
- USE_UNSIGNED_TABLES, 0: sample coding. 0 = signed two's complement; 1 = unsigned offset-binary. Must match the table setting.
- HYST, 256: hysteresis half-width in LSBs around mid-scale, range 1..2047.
- CNT_WIDTH, 16: width of the period and first-half counters.
- MIN_PERIOD, 2: shortest accepted period, in samples. Shorter periods are discarded as glitches.

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst_n  in  1  asynchronous active-low reset
- sampleValid  in  1  qualifies sample for one clock
- sample  in  12  square-wave sample
- phaseTopBit  out  1  decoded phase top bit, registered
- period  out  CNT_WIDTH  last measured period, in samples
- firstHalf  out  CNT_WIDTH  samples with phaseTopBit=0 within the last period
- periodValid  out  1  one-clock pulse when period and firstHalf update
- locked  out  1  at least one valid period measured since reset or timeout
- timeout  out  1  sticky; period counter saturated

Behaviour:
- Reset (async, rst_n=0): phaseTopBit=0, period=0, firstHalf=0, periodValid=0, locked=0, timeout=0, counters=0, state=UNKNOWN. Asserting reset mid-measurement drops the measurement; nothing is reported.
- Ticks: only clocks with sampleValid=1 are processed. With sampleValid=0, all state holds and periodValid=0.
- Classification, signed mode:
  - $signed(sample) >= HYST → class 1.
  - $signed(sample) <= -HYST → class 0.
  - Otherwise in-band.
- Classification, unsigned mode:
  - sample >= 2048+HYST → class 0.
  - sample <= 2047-HYST → class 1.
  - Otherwise in-band.
- Decoded bit: an in-band sample keeps the previous phaseTopBit. phaseTopBit registers the new class one clock after the sample (latency 1).
- Wrap event: a processed sample whose class is 0 while the registered phaseTopBit is 1 (phase wrap 1→0).
- State UNKNOWN:
  - In-band samples stay in UNKNOWN.
  - The first classified sample loads phaseTopBit and moves to SEEK.
  - No wrap event is possible from UNKNOWN.
- State SEEK: on a wrap event, cnt←1, hcnt←1, go to MEASURE.
- State MEASURE, each processed sample:
  - cnt←cnt+1.
  - hcnt←hcnt+1 if the resulting level is 0.
- MEASURE on a wrap event:
  - If cnt >= MIN_PERIOD: period←cnt, firstHalf←hcnt, periodValid=1 on the next clock, locked←1, timeout←0.
  - If cnt < MIN_PERIOD: outputs unchanged, no pulse.
  - In either case cnt←1, hcnt←1.
- Period definition: period equals the number of samples from one wrap sample (inclusive) to the next (exclusive).
- Saturation: if cnt reaches 2^CNT_WIDTH-1 without a wrap:
  - timeout←1, locked←0, go to SEEK, counters hold.
  - period and firstHalf keep their last values.
- Ordering: periodValid is registered, so it is high in the same cycle that period and firstHalf show their new values.
- Back-to-back wraps: a wrap on every other sample gives period=2 on each wrap, provided MIN_PERIOD<=2.
- Arithmetic: counters are unsigned; no wrap-around is allowed (saturation is handled as above).

Test Plan:
- Signed, HYST=256: stream of 4×0x7FF then 4×0x801, repeated, sampleValid=1 continuously → after the second wrap, periodValid pulses every 8 samples with period=8, firstHalf=4; locked=1.
- Unsigned: 6×0x000, 10×0xFFF repeated → period=16, firstHalf=10; phaseTopBit=1 during 0x000 samples and 0 during 0xFFF samples, one clock late.
- Hysteresis: signed 0x7FF, 0x0F0 (+240, in-band), 0x801, 0xF10 (−240), 0x7FF → phaseTopBit follows 1,1,0,0,1. Exactly one wrap event, at the 0x801 sample.
- Gapped valid: the first test's pattern with sampleValid toggling 1,0 → still period=8, firstHalf=4; the periodValid spacing in clocks doubles.
- Timeout with CNT_WIDTH=4: wrap, then constant 0x801 for 15 samples → timeout=1, locked=0, period unchanged. Next full cycle pair restores locked=1 and clears timeout.
- Reset mid-period: assert rst_n=0 for 1 clock during MEASURE → all outputs 0 immediately. State is UNKNOWN; the next report requires a classified sample plus two wraps.
